pattern_seq: RTL
================

# pattern_seq

Sequencer for the dual 8-bit rotating LED pattern datapath. It loads seed patterns, steps both channels at a programmable prescaled rate in one of four rotation modes, and runs for a fixed number of steps or indefinitely. It supports pause/stop control and reports status through `busy` and `done`. It sits between the board's push-button/switch logic and the two 8-bit LED buses.

## Interface

**Parameters**
- `PRESCALE`, default 4: clock cycles per pattern step. Legal range 1..65535; 1 means step every clock.
- `STEPS`, default 8: steps per run. Legal range 0..255; 0 means run until `stop`.

**Ports** (name, direction, width, meaning)
- `clk` input 1: single clock, rising edge.
- `areset` input 1: asynchronous, active-low reset.
- `start` input 1: synchronous pulse; begins a run when IDLE.
- `stop` input 1: synchronous pulse; aborts a run.
- `hold` input 1: level; pauses stepping while high.
- `mode` input 2: rotation mode, latched at start.
- `seed1` input 8: initial Q1 value, latched at start.
- `seed2` input 8: initial Q2 value, latched at start.
- `Q1` output 8: channel 1 pattern, registered.
- `Q2` output 8: channel 2 pattern, registered.
- `busy` output 1: high in RUN or PAUSE.
- `done` output 1: one-cycle pulse on normal completion.

## Operation

**FSM states**
- IDLE → RUN: on `start` & !`stop`.
  - Latch `mode`, `seed1`→Q1, `seed2`→Q2.
  - Clear prescaler, step counter and direction counter; set dir=fwd.
- RUN → PAUSE: on `hold`=1 (and !`stop`).
- PAUSE → RUN: on `hold`=0.
- RUN or PAUSE → IDLE: on `stop`. Q1/Q2 hold their current value; `done` stays 0.
- RUN → IDLE: on the final step when STEPS≠0. `done`=1 for exactly one cycle.

**Prescaler**
- Counts 0..PRESCALE-1, advancing only in RUN with `hold`=0.
- A tick occurs when it wraps to 0.
- Frozen in PAUSE; resumes from the frozen value.

**Step on tick**, using rotl x = {x[6:0],x[7]} and rotr x = {x[0],x[7:1]}:
- 00: Q1=rotl, Q2=rotl.
- 01: Q1=rotr, Q2=rotr.
- 10: Q1=rotl, Q2=rotr.
- 11 (bounce):
  - fwd: Q1=rotl, Q2=rotr; reverse: Q1=rotr, Q2=rotl.
  - dir toggles after every 7th step, so steps 1–7 fwd, 8–14 reverse, and so on.
  - Direction counter is 3 bits, counting 0..6.

**Step counter**
- 8-bit, increments per step.
- When STEPS≠0 and the count reaches STEPS, that step is applied and the FSM goes to IDLE.
- When STEPS=0 it wraps at 255 and is otherwise unused.

**Ignored inputs**
- `start` outside IDLE has no effect.
- `mode` and seed changes during a run have no effect.

**Simultaneous events (priority)**
- `stop` > `start` in IDLE: no run starts.
- `stop` > final step: no step applied, `done`=0.
- `hold` > tick: no step, prescaler frozen.

## Timing

**Reset** (asynchronous, immediate; includes reset mid-run):
- Q1=8'h01, Q2=8'h66, `busy`=0, `done`=0.
- State IDLE, all counters 0, dir=fwd.

**Run sequence**
- `start` sampled at edge k: Q1/Q2 = seeds and `busy`=1 after edge k.
- Step n is applied at edge k+n·PRESCALE, assuming no hold.
- Each PAUSE cycle delays all later steps by one cycle.
- Final step at edge k+STEPS·PRESCALE: `busy`→0 and `done`→1 on that edge; `done`→0 on the next edge.

**Stop**
- `stop` sampled at edge m: `busy`=0 after edge m, with no further Q change.

**Outputs**
- All outputs are registered with no combinational input-to-output path.

## Test plan

1. **Reset:** assert `areset`=0 asynchronously → Q1=01, Q2=66, `busy`=0, `done`=0 without waiting for a clock edge.
2. **Mode 00, PRESCALE=4, STEPS=3, seeds 81/0F:** `start` at edge 0.
   - Edge 4 → 03/1E; edge 8 → 06/3C; edge 12 → 0C/78.
   - `done`=1 for the single cycle after edge 12, `busy`=0; Q holds 0C/78.
3. **Mode 10, STEPS=0, seeds 01/01:** after 2 steps → Q1=04, Q2=40.
   - After 300 steps `busy` is still 1 and `done` is never asserted.
4. **Mode 11, seeds 01/80, PRESCALE=1:**
   - Step 7 → 80/01.
   - Step 8 → 40/02.
   - Step 14 → 01/80.
   - Step 15 → 02/40.
5. **Hold and stop, PRESCALE=4:**
   - `hold`=1 for 10 cycles starting 2 cycles after step 1 → step 2 lands 10 cycles late, at edge k+18.
   - `stop` together with the final tick → Q unchanged, `busy`=0, `done`=0.
   - `start`+`stop` together in IDLE → remains IDLE.
6. **Reset mid-run:** assert `areset`=0 mid-run (PAUSE state) → immediate 01/66, `busy`=0. After release, a fresh `start` runs normally from the new seeds.

Source files
------------

// File: rtl/pattern_seq_if.sv
// Control, seed and LED-bus bundle for the pattern sequencer.
// The master drives the control and seed inputs, and the slave returns the two LED patterns and the status flags.
interface pattern_seq_if;
    logic       start;
    logic       stop;
    logic       hold;
    logic [1:0] mode;
    logic [7:0] seed1;
    logic [7:0] seed2;
    logic [7:0] Q1;
    logic [7:0] Q2;
    logic       busy;
    logic       done;

    modport master (
        output start, stop, hold, mode, seed1, seed2,
        input  Q1, Q2, busy, done
    );

    modport slave (
        input  start, stop, hold, mode, seed1, seed2,
        output Q1, Q2, busy, done
    );
endinterface

// File: rtl/pattern_seq.sv
// Dual 8-bit rotating LED pattern sequencer.
// A run starts from latched seeds and advances both channels once every PRESCALE clocks.
// It rotates them in one of four modes, and it ends after STEPS steps or, when STEPS is 0, only on stop.
module pattern_seq #(
    parameter int PRESCALE = 4,
    parameter int STEPS    = 8
) (
    input  logic          clk,
    input  logic          areset,
    pattern_seq_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [15:0] PRESC_MAX    = 16'(PRESCALE - 1);
    localparam logic [7:0]  STEPS_END    = 8'(STEPS);
    localparam logic        STEPS_FINITE = (STEPS != 0);

    state_t      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  step_q, step_d;
    logic [2:0]  dir_cnt_q, dir_cnt_d;
    logic        dir_q, dir_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  q1_q, q1_d;
    logic [7:0]  q2_q, q2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  step_inc;
    logic        tick;

    function automatic logic [7:0] rotl(input logic [7:0] x);
        return {x[6:0], x[7]};
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] x);
        return {x[0], x[7:1]};
    endfunction

    // Next-state logic. Stop beats everything else, and hold beats a prescaler tick.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        step_d    = step_q;
        dir_cnt_d = dir_cnt_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        q1_d      = q1_q;
        q2_d      = q2_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        step_inc  = step_q + 8'd1;
        tick      = (presc_q == PRESC_MAX);

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_d   = RUN;
                    mode_d    = bus.mode;
                    q1_d      = bus.seed1;
                    q2_d      = bus.seed2;
                    presc_d   = 16'd0;
                    step_d    = 8'd0;
                    dir_cnt_d = 3'd0;
                    dir_d     = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            RUN, PAUSE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (bus.hold) begin
                    state_d = PAUSE;
                end else begin
                    state_d = RUN;
                    if (tick) begin
                        presc_d = 16'd0;
                        step_d  = step_inc;
                        // The bounce direction flips after every 7th step.
                        if (dir_cnt_q == 3'd6) begin
                            dir_cnt_d = 3'd0;
                            dir_d     = ~dir_q;
                        end else begin
                            dir_cnt_d = dir_cnt_q + 3'd1;
                        end
                        case (mode_q)
                            2'b00: begin
                                q1_d = rotl(q1_q);
                                q2_d = rotl(q2_q);
                            end
                            2'b01: begin
                                q1_d = rotr(q1_q);
                                q2_d = rotr(q2_q);
                            end
                            2'b10: begin
                                q1_d = rotl(q1_q);
                                q2_d = rotr(q2_q);
                            end
                            default: begin
                                q1_d = dir_q ? rotr(q1_q) : rotl(q1_q);
                                q2_d = dir_q ? rotl(q2_q) : rotr(q2_q);
                            end
                        endcase
                        if (STEPS_FINITE && (step_inc == STEPS_END)) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers. Reset restores the power-on LED pattern.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q   <= IDLE;
            presc_q   <= 16'd0;
            step_q    <= 8'd0;
            dir_cnt_q <= 3'd0;
            dir_q     <= 1'b0;
            mode_q    <= 2'b00;
            q1_q      <= 8'h01;
            q2_q      <= 8'h66;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            step_q    <= step_d;
            dir_cnt_q <= dir_cnt_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            q1_q      <= q1_d;
            q2_q      <= q2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.Q1   = q1_q;
    assign bus.Q2   = q2_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
